// File: rtl/quad_snap_if.sv
// Snapshot handshake bundle between the sample scheduler and the register bank.
// The master presents positions/velocities with snap_valid; the slave returns snap_ack.
interface quad_snap_if #(
    parameter int CNT_WIDTH = 16
);
    logic [CNT_WIDTH-1:0] pos0;
    logic [CNT_WIDTH-1:0] pos1;
    logic [CNT_WIDTH-1:0] vel0;
    logic [CNT_WIDTH-1:0] vel1;
    logic                 snap_valid;
    logic                 snap_ack;

    modport master (
        output pos0, pos1, vel0, vel1, snap_valid,
        input  snap_ack
    );

    modport slave (
        input  pos0, pos1, vel0, vel1, snap_valid,
        output snap_ack
    );
endinterface

// File: rtl/quad_sample_sched.sv
// Periodic sample scheduler: latches both encoder counts together, derives
// per-interval deltas, and hands the snapshot over a valid/ack handshake.
module quad_sample_sched #(
    parameter int CNT_WIDTH = 16,
    parameter int PRE_WIDTH = 16,
    parameter int PER_WIDTH = 8
) (
    input  logic                 hba_clk,
    input  logic                 hba_reset_n,
    input  logic                 en,
    input  logic [PRE_WIDTH-1:0] prescale,
    input  logic [PER_WIDTH-1:0] period,
    input  logic                 sample_now,
    input  logic [CNT_WIDTH-1:0] count0,
    input  logic [CNT_WIDTH-1:0] count1,
    input  logic                 clr_overrun,
    input  logic                 irq_en,
    output logic                 overrun,
    output logic [7:0]           miss_cnt,
    output logic                 irq,
    quad_snap_if.master          snap
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [PER_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_WIDTH-1:0] prev0_q, prev0_d;
    logic [CNT_WIDTH-1:0] prev1_q, prev1_d;
    logic [CNT_WIDTH-1:0] pos0_q, pos0_d;
    logic [CNT_WIDTH-1:0] pos1_q, pos1_d;
    logic [CNT_WIDTH-1:0] vel0_q, vel0_d;
    logic [CNT_WIDTH-1:0] vel1_q, vel1_d;
    logic                 primed_q, primed_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           miss_q, miss_d;

    logic tick;
    logic sample_evt;
    logic latch;
    logic drop;

    assign tick       = en && (pre_cnt_q == prescale);
    assign sample_evt = en && (sample_now || (tick && per_cnt_q == period));
    assign latch      = sample_evt && (state_q == EMPTY || snap.snap_ack);
    assign drop       = sample_evt && state_q == FULL && !snap.snap_ack;

    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
        per_cnt_d = per_cnt_q;
        if (!en || sample_now || tick) begin
            pre_cnt_d = '0;
        end
        if (!en || sample_now) begin
            per_cnt_d = '0;
        end else if (tick) begin
            per_cnt_d = (per_cnt_q == period) ? '0 : per_cnt_q + PER_WIDTH'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        prev0_d  = prev0_q;
        prev1_d  = prev1_q;
        pos0_d   = pos0_q;
        pos1_d   = pos1_q;
        vel0_d   = vel0_q;
        vel1_d   = vel1_q;
        primed_d = primed_q && en;
        if (latch) begin
            state_d  = FULL;
            pos0_d   = count0;
            pos1_d   = count1;
            prev0_d  = count0;
            prev1_d  = count1;
            // First sample after enable/reset has no valid reference point
            vel0_d   = primed_q ? count0 - prev0_q : '0;
            vel1_d   = primed_q ? count1 - prev1_q : '0;
            primed_d = 1'b1;
        end else if (state_q == FULL && snap.snap_ack && !sample_evt) begin
            state_d = EMPTY;
        end
    end

    // A drop in the same cycle as a clear wins so no miss goes unreported
    always_comb begin
        overrun_d = overrun_q;
        miss_d    = miss_q;
        if (drop) begin
            overrun_d = 1'b1;
            if (clr_overrun) begin
                miss_d = 8'd1;
            end else if (miss_q != 8'hFF) begin
                miss_d = miss_q + 8'd1;
            end
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
            miss_d    = 8'd0;
        end
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state_q   <= EMPTY;
            pre_cnt_q <= '0;
            per_cnt_q <= '0;
            prev0_q   <= '0;
            prev1_q   <= '0;
            pos0_q    <= '0;
            pos1_q    <= '0;
            vel0_q    <= '0;
            vel1_q    <= '0;
            primed_q  <= 1'b0;
            overrun_q <= 1'b0;
            miss_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            per_cnt_q <= per_cnt_d;
            prev0_q   <= prev0_d;
            prev1_q   <= prev1_d;
            pos0_q    <= pos0_d;
            pos1_q    <= pos1_d;
            vel0_q    <= vel0_d;
            vel1_q    <= vel1_d;
            primed_q  <= primed_d;
            overrun_q <= overrun_d;
            miss_q    <= miss_d;
        end
    end

    assign snap.pos0       = pos0_q;
    assign snap.pos1       = pos1_q;
    assign snap.vel0       = vel0_q;
    assign snap.vel1       = vel1_q;
    assign snap.snap_valid = (state_q == FULL);
    assign overrun         = overrun_q;
    assign miss_cnt        = miss_q;
    assign irq             = (state_q == FULL) && irq_en;

endmodule

// File: doc/quad_sample_sched.md
# quad_sample_sched

Periodic sample scheduler for the two quadrature pulse counters feeding `hba_quad`. It generates a programmable sample strobe and atomically latches both 16-bit encoder counts in the same cycle. It computes a signed per-interval delta (velocity) for each encoder and presents the snapshot to the register bank through a valid/ack handshake, with overrun tracking. It sits between the `pulse_counter` outputs and the HBA register bank, and is configured from control registers.

## Interface
Parameters:
- `CNT_WIDTH`, 16, width of encoder counts, positions and deltas
- `PRE_WIDTH`, 16, width of the prescaler reload value
- `PER_WIDTH`, 8, width of the period (ticks per sample) value

Ports:
- `hba_clk`  in  1  single clock for the block
- `hba_reset_n`  in  1  asynchronous, active-low reset
- `en`  in  1  scheduler enable (level)
- `prescale`  in  PRE_WIDTH  clock cycles per tick, minus 1
- `period`  in  PER_WIDTH  ticks per sample, minus 1
- `sample_now`  in  1  single-cycle software-triggered sample request
- `count0`, `count1`  in  CNT_WIDTH each  live counts from the left/right pulse counters
- `snap_ack`  in  1  consumer has taken the snapshot
- `clr_overrun`  in  1  clears `overrun` and `miss_cnt`
- `irq_en`  in  1  interrupt enable
- `pos0`, `pos1`  out  CNT_WIDTH each  latched counts
- `vel0`, `vel1`  out  CNT_WIDTH each  signed deltas since the previous delivered sample
- `snap_valid`  out  1  snapshot pending
- `overrun`  out  1  sticky flag: a sample was dropped
- `miss_cnt`  out  8  saturating count of dropped samples
- `irq`  out  1  equals `snap_valid & irq_en`

## Operation
- Reset: every output is 0. Internal `pre_cnt`, `per_cnt`, `prev0`, `prev1` are 0, and `primed` is 0.
- `en=0`:
  - `pre_cnt` and `per_cnt` are held at 0 and no samples are taken; `sample_now` is ignored.
  - `primed` is cleared.
  - A pending snapshot stays valid until it is acked.
- `en=1`, prescaler:
  - `pre_cnt` increments each cycle.
  - When `pre_cnt==prescale`, it sets `tick` and `pre_cnt` wraps to 0.
- `en=1`, period:
  - On `tick`, `per_cnt` increments.
  - When `tick && per_cnt==period`, it sets `sample_evt` and `per_cnt` wraps to 0.
  - Sample interval is exactly (prescale+1)*(period+1) cycles.
- `sample_now` with `en=1`:
  - Raises `sample_evt` that cycle.
  - Restarts `pre_cnt` and `per_cnt` at 0.
  - Coinciding with a natural `sample_evt`, it produces one sample only.
- `prescale`/`period` changes take effect at the next comparison. If a new value is below the current count, the counter runs through wrap at 2^width.
- States:
  - `EMPTY` (snap_valid=0)
    - `sample_evt` → latch → `FULL`.
  - `FULL` (snap_valid=1)
    - `snap_ack` alone → `EMPTY`.
    - `sample_evt` with `snap_ack` in the same cycle → latch new snapshot, stay `FULL`, no overrun.
    - `sample_evt` without `snap_ack` → drop: no latch, `prev*` unchanged, `overrun<=1`, `miss_cnt` += 1 saturating at 255.
- Latch:
  - `pos0<=count0`, `prev0<=count0`, and likewise for channel 1.
  - `vel0<=count0-prev0`, modulo 2^CNT_WIDTH. Two's-complement wrap is correct: 0x0002-0xFFFE = 0x0004.
  - If `primed=0`, `vel*<=0` and `primed<=1`, so the first sample after enable or reset has zero velocity.
  - After a dropped sample, the next delta spans multiple intervals. This is intended.
- `clr_overrun` clears `overrun` and `miss_cnt`. If a drop occurs in the same cycle, the drop wins: `overrun=1`, `miss_cnt=1`.
- `snap_ack` while `EMPTY` is ignored.

## Timing
- `sample_evt` in cycle N:
  - `pos*`, `vel*` and `snap_valid` update at the edge ending cycle N and are visible in N+1.
  - `count*` is sampled in cycle N, so both channels are coherent.
- `snap_ack` high in cycle M while `FULL`: `snap_valid=0` in M+1. `irq` follows with no extra delay.
- First natural sample after `en` rises in cycle E occurs in cycle E + (prescale+1)*(period+1) - 1.
- `hba_reset_n` assertion, including mid-snapshot, clears all state immediately (asynchronous). Deassertion is synchronized by the system reset tree.
- No combinational path from inputs to outputs except `irq_en`→`irq`.

## Test plan
- Periodic sampling: prescale=3, period=1, en=1, counts ramp +1/cycle, ack one cycle after each valid → `snap_valid` every 8 cycles, first `vel0=0`, subsequent `vel0=8`.
- Wraparound: `prev0=0xFFFE`, `count0=0x0002` at sample → `vel0=0x0004`. Reverse direction gives `vel0=0xFFFC`.
- Overrun: never ack, 3 intervals elapse → `pos*` hold first snapshot, `overrun=1`, `miss_cnt=2`. Ack, then next sample: `vel0` spans 3 intervals. `clr_overrun` → both 0.
- Ack/sample coincidence: `snap_ack` in same cycle as `sample_evt` → new snapshot latched, `snap_valid` stays 1, `overrun=0`.
- `sample_now`: pulse mid-interval → snapshot in next cycle, prescale/period counters restart, next natural sample a full interval later. `sample_now` with `en=0` → no effect.
- Reset mid-operation: drop `hba_reset_n` while `FULL` with `irq_en=1` → all outputs 0 immediately. After release and enable, first `vel*=0`.
